// File: rtl/regs_wb_arbiter_if.sv
// Write-back request bus between the EX/MEM/MD producers and the register-file write-port arbiter.
// Handshake: a transfer happens when valid && ready in the same cycle; a requester holds valid/addr/data stable until accepted.
interface regs_wb_arbiter_if #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32
);
  logic              i_ex_valid;
  logic [ADDR_W-1:0] i_ex_addr;
  logic [DATA_W-1:0] i_ex_data;
  logic              o_ex_ready;

  logic              i_mem_valid;
  logic [ADDR_W-1:0] i_mem_addr;
  logic [DATA_W-1:0] i_mem_data;
  logic              o_mem_ready;

  logic              i_md_valid;
  logic [ADDR_W-1:0] i_md_addr;
  logic [DATA_W-1:0] i_md_data;
  logic              o_md_ready;

  logic              o_we;
  logic [ADDR_W-1:0] o_w_addr;
  logic [DATA_W-1:0] o_w_data;
  logic              o_stall_ex;

  modport master (
    output i_ex_valid, i_ex_addr, i_ex_data,
    output i_mem_valid, i_mem_addr, i_mem_data,
    output i_md_valid, i_md_addr, i_md_data,
    input  o_ex_ready, o_mem_ready, o_md_ready,
    input  o_we, o_w_addr, o_w_data, o_stall_ex
  );

  modport slave (
    input  i_ex_valid, i_ex_addr, i_ex_data,
    input  i_mem_valid, i_mem_addr, i_mem_data,
    input  i_md_valid, i_md_addr, i_md_data,
    output o_ex_ready, o_mem_ready, o_md_ready,
    output o_we, o_w_addr, o_w_data, o_stall_ex
  );
endinterface

// File: rtl/regs_wb_arbiter.sv
// Register-file write-port arbiter: EX > MEM > MD with starvation-guard forced grants.
// Optional macro WB_ARB_RR_EN swaps fixed priority for round-robin (forced grants kept).
module regs_wb_arbiter #(
  parameter int ADDR_W   = 5,
  parameter int DATA_W   = 32,
  parameter int MAX_WAIT = 4
) (
  input  logic              i_Clk,
  input  logic              i_reset,
  regs_wb_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {
    SRC_EX   = 2'd0,
    SRC_MEM  = 2'd1,
    SRC_MD   = 2'd2,
    SRC_NONE = 2'd3
  } src_e;

  localparam logic [3:0] MAX_CNT = 4'(MAX_WAIT);

  logic [3:0]        cnt_mem, cnt_md;
  logic              req_ex, req_mem, req_md;
  logic              force_mem, force_md;
  src_e              grant;
  logic [ADDR_W-1:0] grant_addr;
  logic [DATA_W-1:0] grant_data;

`ifdef WB_ARB_RR_EN
  src_e last_grant;
`endif

  assign req_ex    = bus.i_ex_valid  && (bus.i_ex_addr  != '0);
  assign req_mem   = bus.i_mem_valid && (bus.i_mem_addr != '0);
  assign req_md    = bus.i_md_valid  && (bus.i_md_addr  != '0);
  assign force_mem = req_mem && (cnt_mem >= MAX_CNT);
  assign force_md  = req_md  && (cnt_md  >= MAX_CNT);

  // A starved requester wins outright; equal counters favour MEM.
  always_comb begin
    grant = SRC_NONE;
    if (i_reset) begin
      grant = SRC_NONE;
    end else if (force_mem && (!force_md || (cnt_mem >= cnt_md))) begin
      grant = SRC_MEM;
    end else if (force_md) begin
      grant = SRC_MD;
    end else begin
`ifdef WB_ARB_RR_EN
      case (last_grant)
        SRC_EX: begin
          if (req_mem)     grant = SRC_MEM;
          else if (req_md) grant = SRC_MD;
          else if (req_ex) grant = SRC_EX;
        end
        SRC_MEM: begin
          if (req_md)       grant = SRC_MD;
          else if (req_ex)  grant = SRC_EX;
          else if (req_mem) grant = SRC_MEM;
        end
        default: begin
          if (req_ex)       grant = SRC_EX;
          else if (req_mem) grant = SRC_MEM;
          else if (req_md)  grant = SRC_MD;
        end
      endcase
`else
      if (req_ex)       grant = SRC_EX;
      else if (req_mem) grant = SRC_MEM;
      else if (req_md)  grant = SRC_MD;
`endif
    end
  end

  always_comb begin
    grant_addr = bus.i_ex_addr;
    grant_data = bus.i_ex_data;
    case (grant)
      SRC_MEM: begin
        grant_addr = bus.i_mem_addr;
        grant_data = bus.i_mem_data;
      end
      SRC_MD: begin
        grant_addr = bus.i_md_addr;
        grant_data = bus.i_md_data;
      end
      default: ;
    endcase
  end

  // x0 requests are accepted immediately in parallel with the normal grant.
  assign bus.o_ex_ready  = !i_reset && bus.i_ex_valid  && ((bus.i_ex_addr  == '0) || (grant == SRC_EX));
  assign bus.o_mem_ready = !i_reset && bus.i_mem_valid && ((bus.i_mem_addr == '0) || (grant == SRC_MEM));
  assign bus.o_md_ready  = !i_reset && bus.i_md_valid  && ((bus.i_md_addr  == '0) || (grant == SRC_MD));
  assign bus.o_stall_ex  = bus.i_ex_valid && !bus.o_ex_ready;

  always_ff @(posedge i_Clk) begin
    if (i_reset) begin
      cnt_mem <= '0;
      cnt_md  <= '0;
    end else begin
      if (!req_mem || (grant == SRC_MEM)) cnt_mem <= '0;
      else if (cnt_mem < MAX_CNT)         cnt_mem <= cnt_mem + 4'd1;
      if (!req_md || (grant == SRC_MD))   cnt_md  <= '0;
      else if (cnt_md < MAX_CNT)          cnt_md  <= cnt_md + 4'd1;
    end
  end

  always_ff @(posedge i_Clk) begin
    if (i_reset) begin
      bus.o_we     <= 1'b0;
      bus.o_w_addr <= '0;
      bus.o_w_data <= '0;
    end else begin
      bus.o_we <= (grant != SRC_NONE);
      if (grant != SRC_NONE) begin
        bus.o_w_addr <= grant_addr;
        bus.o_w_data <= grant_data;
      end
    end
  end

`ifdef WB_ARB_RR_EN
  always_ff @(posedge i_Clk) begin
    if (i_reset)                 last_grant <= SRC_MD;
    else if (grant != SRC_NONE)  last_grant <= grant;
  end
`endif

endmodule

// File: tb/tb_regs_wb_arbiter.sv
// Bench for regs_wb_arbiter: directed scenarios plus randomized traffic checked against a queue-free behavioural model.
module tb_regs_wb_arbiter;
  localparam int ADDR_W   = 5;
  localparam int DATA_W   = 32;
  localparam int MAX_WAIT = 4;
  localparam int N_RAND   = 3000;

  logic clk;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  regs_wb_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  regs_wb_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_WAIT(MAX_WAIT)) dut (
    .i_Clk   (clk),
    .i_reset (rst),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Requester-side state: index 0 = EX, 1 = MEM, 2 = MD.
  bit                v[3];
  logic [ADDR_W-1:0] a[3];
  logic [DATA_W-1:0] d[3];

  // Behavioural model state.
  int                m_cnt[3];
  int                m_last;
  int                m_grant;
  bit                m_rdy[3];
  bit                m_stall;
  logic              m_we;
  logic [ADDR_W-1:0] m_addr;
  logic [DATA_W-1:0] m_data;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic apply_inputs();
    bus.i_ex_valid  = v[0]; bus.i_ex_addr  = a[0]; bus.i_ex_data  = d[0];
    bus.i_mem_valid = v[1]; bus.i_mem_addr = a[1]; bus.i_mem_data = d[1];
    bus.i_md_valid  = v[2]; bus.i_md_addr  = a[2]; bus.i_md_data  = d[2];
  endtask

  // Decide this cycle's winner from the rules: starved MEM/MD first, else priority order.
  task automatic model_comb();
    bit req[3];
    int best;
    for (int k = 0; k < 3; k++) req[k] = v[k] && (a[k] != 0);
    m_grant = -1;
    if (!rst) begin
      best = -1;
      for (int k = 1; k < 3; k++)
        if (req[k] && m_cnt[k] >= MAX_WAIT && (best < 0 || m_cnt[k] > m_cnt[best])) best = k;
      if (best >= 0) m_grant = best;
      else begin
`ifdef WB_ARB_RR_EN
        for (int off = 1; off <= 3; off++)
          if (m_grant < 0 && req[(m_last + off) % 3]) m_grant = (m_last + off) % 3;
`else
        for (int k = 0; k < 3; k++)
          if (m_grant < 0 && req[k]) m_grant = k;
`endif
      end
    end
    for (int k = 0; k < 3; k++) m_rdy[k] = !rst && v[k] && (a[k] == 0 || m_grant == k);
    m_stall = v[0] && !m_rdy[0];
  endtask

  task automatic model_seq();
    for (int k = 1; k < 3; k++) begin
      if (rst || !v[k] || a[k] == 0 || m_grant == k) m_cnt[k] = 0;
      else if (m_cnt[k] < MAX_WAIT) m_cnt[k] = m_cnt[k] + 1;
    end
    if (rst) begin
      m_we = 1'b0; m_addr = '0; m_data = '0; m_last = 2;
    end else begin
      m_we = (m_grant >= 0);
      if (m_grant >= 0) begin
        m_addr = a[m_grant]; m_data = d[m_grant]; m_last = m_grant;
      end
    end
  endtask

  // Called at a negedge with inputs prepared; returns at the next negedge.
  task automatic do_cycle();
    apply_inputs();
    #1;
    model_comb();
    chk("ex_ready",  bus.o_ex_ready,  m_rdy[0]);
    chk("mem_ready", bus.o_mem_ready, m_rdy[1]);
    chk("md_ready",  bus.o_md_ready,  m_rdy[2]);
    chk("stall_ex",  bus.o_stall_ex,  m_stall);
    chk("we",        bus.o_we,        m_we);
    chk("w_addr",    bus.o_w_addr,    m_addr);
    chk("w_data",    bus.o_w_data,    m_data);
    @(posedge clk);
    model_seq();
    @(negedge clk);
  endtask

  task automatic consume();
    for (int k = 0; k < 3; k++) if (v[k] && (m_rdy[k] || rst)) v[k] = 0;
  endtask

  task automatic clear_all();
    for (int k = 0; k < 3; k++) begin v[k] = 0; a[k] = '0; d[k] = '0; end
  endtask

  initial begin
    clear_all();
    m_cnt = '{0, 0, 0}; m_last = 2; m_we = 1'b0; m_addr = '0; m_data = '0; m_grant = -1;
    rst = 1'b1;
    apply_inputs();
    @(negedge clk);
    do_cycle();
    do_cycle();
    rst = 1'b0;
    chk("reset_we", bus.o_we, 1'b0);
    chk("reset_w_addr", bus.o_w_addr, 0);
    chk("reset_w_data", bus.o_w_data, 0);

    // Single EX write.
    v[0] = 1; a[0] = 5; d[0] = 32'hDEADBEEF;
    apply_inputs(); #1;
    chk("t1_ex_ready", bus.o_ex_ready, 1'b1);
    do_cycle(); consume();
    chk("t1_we", bus.o_we, 1'b1);
    chk("t1_w_addr", bus.o_w_addr, 5);
    chk("t1_w_data", bus.o_w_data, 32'hDEADBEEF);
    do_cycle();
    chk("t1_we_idle", bus.o_we, 1'b0);

    // EX and MEM collide.
    v[0] = 1; a[0] = 3; d[0] = 32'h33;
    v[1] = 1; a[1] = 4; d[1] = 32'h44;
    apply_inputs(); #1;
    chk("t2_ex_ready", bus.o_ex_ready, 1'b1);
    chk("t2_mem_ready0", bus.o_mem_ready, 1'b0);
    do_cycle(); consume();
    apply_inputs(); #1;
    chk("t2_mem_ready1", bus.o_mem_ready, 1'b1);
    chk("t2_w_addr1", bus.o_w_addr, 3);
    do_cycle(); consume();
    chk("t2_w_addr2", bus.o_w_addr, 4);
    do_cycle();

`ifndef WB_ARB_RR_EN
    // MEM starved by continuous EX traffic is forced through after MAX_WAIT cycles.
    v[1] = 1; a[1] = 7; d[1] = 32'h77;
    for (int i = 0; i <= MAX_WAIT; i++) begin
      if (!v[0]) begin v[0] = 1; a[0] = 5'(10 + i); d[0] = 32'(i); end
      apply_inputs(); #1;
      chk("t3_mem_ready", bus.o_mem_ready, (i == MAX_WAIT));
      chk("t3_stall_ex", bus.o_stall_ex, (i == MAX_WAIT));
      do_cycle(); consume();
    end
    chk("t3_forced_we", bus.o_we, 1'b1);
    chk("t3_forced_addr", bus.o_w_addr, 7);
    do_cycle(); consume();
    do_cycle();
`endif

    // x0 request completes alongside a normal grant.
    v[2] = 1; a[2] = 0; d[2] = 32'hBAD0;
    v[0] = 1; a[0] = 9; d[0] = 32'h99;
    apply_inputs(); #1;
    chk("t4_md_ready", bus.o_md_ready, 1'b1);
    chk("t4_ex_ready", bus.o_ex_ready, 1'b1);
    do_cycle(); consume();
    chk("t4_we", bus.o_we, 1'b1);
    chk("t4_w_addr", bus.o_w_addr, 9);
    do_cycle();
    chk("t4_we_once", bus.o_we, 1'b0);

    // Reset arriving during an EX grant.
    v[0] = 1; a[0] = 12; d[0] = 32'h12;
    v[1] = 1; a[1] = 13; d[1] = 32'h13;
    do_cycle(); consume();
    v[0] = 1; a[0] = 14; d[0] = 32'h14;
    v[2] = 1; a[2] = 0;
    rst = 1'b1;
    apply_inputs(); #1;
    chk("t5_ex_ready_rst", bus.o_ex_ready, 1'b0);
    chk("t5_mem_ready_rst", bus.o_mem_ready, 1'b0);
    chk("t5_md_ready_rst", bus.o_md_ready, 1'b0);
    chk("t5_we_before", bus.o_we, 1'b1);
    do_cycle(); consume();
    rst = 1'b0;
    chk("t5_we_suppressed", bus.o_we, 1'b0);
    chk("t5_w_addr_cleared", bus.o_w_addr, 0);
`ifndef WB_ARB_RR_EN
    // A cleared MEM counter needs the full MAX_WAIT cycles again.
    v[1] = 1; a[1] = 13; d[1] = 32'h13;
    for (int i = 0; i <= MAX_WAIT; i++) begin
      if (!v[0]) begin v[0] = 1; a[0] = 5'(20 + i); d[0] = 32'(i); end
      apply_inputs(); #1;
      chk("t5_mem_recount", bus.o_mem_ready, (i == MAX_WAIT));
      do_cycle(); consume();
    end
`endif
    clear_all();
    do_cycle();

`ifdef WB_ARB_RR_EN
    // Round-robin order from reset: EX, MEM, MD, ...
    rst = 1'b1; do_cycle(); rst = 1'b0;
    for (int i = 0; i < 7; i++) begin
      for (int k = 0; k < 3; k++) if (!v[k]) begin v[k] = 1; a[k] = 5'(k + 1); d[k] = 32'(i * 16 + k); end
      apply_inputs(); #1;
      if (i > 0) begin
        chk("t6_we", bus.o_we, 1'b1);
        chk("t6_w_addr", bus.o_w_addr, ((i - 1) % 3) + 1);
      end
      chk("t6_ready_rr", (i % 3 == 0) ? bus.o_ex_ready : (i % 3 == 1) ? bus.o_mem_ready : bus.o_md_ready, 1'b1);
      do_cycle(); consume();
    end
    clear_all();
    do_cycle();
`endif

    // Random traffic against the model.
    for (int n = 0; n < N_RAND; n++) begin
      rst = ($urandom_range(0, 99) == 0);
      for (int k = 0; k < 3; k++) begin
        if (!v[k] && $urandom_range(0, 99) < 60) begin
          v[k] = 1;
          a[k] = ($urandom_range(0, 7) == 0) ? '0 : 5'($urandom_range(1, 31));
          d[k] = $urandom;
        end
      end
      do_cycle(); consume();
    end
    rst = 1'b0;
    clear_all();
    do_cycle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
